if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, instruction buffer entries and maximum in-flight fetches.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port redirect_valid  input  1  taken branch/jump from execute.
REQ-006 SHALL have port redirect_pc  input  32  redirect target address.
REQ-007 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-008 SHALL have port imem_addr  output  32  fetch address, valid while imem_req=1.
REQ-009 SHALL have port imem_gnt  input  1  memory accepts the request this cycle.
REQ-010 SHALL have port imem_rvalid  input  1  response strobe, one per grant, in order, at least 1 cycle after grant.
REQ-011 SHALL have port imem_rdata  input  32  instruction word for the oldest outstanding grant.
REQ-012 SHALL have port id_valid  output  1  decode-stage instruction valid.
REQ-013 SHALL have port id_pc  output  32  address of the presented instruction.
REQ-014 SHALL have port id_instr  output  32  presented instruction word.
REQ-015 SHALL have port id_ready  input  1  decode accepts this cycle (0 = stall).

Function
REQ-016 SHALL hold fetch PC register; imem_addr = fetch PC; imem_req = 1 when outstanding + buffered < DEPTH and no redirect this cycle.
REQ-017 SHALL advance fetch PC by 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0) on each cycle with imem_req & imem_gnt.
REQ-018 SHALL record the PC of every granted request in issue order, paired with its response.
REQ-019 SHALL write {pc, imem_rdata} into the buffer on imem_rvalid; buffered entry visible on id_* the next cycle (1-cycle response-to-decode latency).
REQ-020 SHALL present buffer head on id_valid/id_pc/id_instr; pop on id_valid & id_ready; hold id_* stable while id_valid & !id_ready.
REQ-021 SHALL never overflow: credit rule of REQ-016 guarantees space; push and pop in same cycle on full buffer permitted.
REQ-022 SHALL on redirect_valid: load fetch PC with {redirect_pc[31:2],2'b00} next edge, flush buffer (id_valid=0 next cycle), mark all outstanding grants as to-drop.
REQ-023 SHALL discard responses of to-drop grants; no credit counted for them in buffer, they still count as outstanding until returned.
REQ-024 SHALL give redirect priority over same-cycle grant, rvalid, and pop; no request issued in redirect cycle.
REQ-025 SHALL treat redirect while id_valid & !id_ready as flush; stalled instruction is lost.
REQ-026 SHALL resume requesting at redirect target in the cycle after redirect if credits allow.

Reset
REQ-027 SHALL on rst=1 immediately set fetch PC=RESET_PC, buffer empty, outstanding=0, drop count=0, imem_req=0, id_valid=0, id_pc=0, id_instr=0.
REQ-028 SHALL issue first request (imem_addr=RESET_PC) in first cycle after rst deasserts.
REQ-029 SHALL, on reset mid-operation, ignore any later imem_rvalid belonging to pre-reset grants (memory is reset on same rst).

Structure
REQ-030 SHALL take RESET_PC default, XLEN=32, and PC increment constant from shared package riscv_pkg.
REQ-031 SHALL implement buffer as sub-module fetch_fifo (parameterised width/depth synchronous FIFO with flush).
REQ-032 SHALL keep outstanding counter and drop counter in if_fetch_unit, each log2(DEPTH)+1 bits.

Verification
REQ-033 Reset release, imem_gnt=1, 1-cycle rvalid, id_ready=1 -> imem_addr 0,4,8,...; id_pc 0,4,8 in order, one per cycle in steady state.
REQ-034 id_ready=0 for 5 cycles -> at most 2 entries buffered, imem_req=0 when full, id_pc/id_instr held; release -> order preserved, no loss/duplication.
REQ-035 redirect_valid=1, redirect_pc=32'h0000_0103 with 2 outstanding grants -> next imem_addr=32'h0000_0100, both stale responses dropped, first id_pc=32'h100.
REQ-036 redirect in same cycle as imem_rvalid and id pop -> buffer empty next cycle, rvalid data never reaches id_*.
REQ-037 Fetch PC at 32'hFFFF_FFFC granted -> next imem_addr=0.
REQ-038 rst asserted mid-stream with buffer full -> id_valid=0 and imem_req=0 asynchronously; after release imem_addr=RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-path constants and the decode buffer entry type.
// No logic; imported by the fetch unit.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC           = 32'd4;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; a pushed word is visible at the head one cycle later.
// A push on full is taken only together with a pop; flush overrides push and pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until count says an entry is present.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: credit-limited imem requests, in-order PC tagging of responses, decode buffer.
// Response reaches id_* one cycle after imem_rvalid; id_ready low holds id_* and requests stop once credits are used.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  input  logic            id_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  word_t         pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] buf_count, tag_count;
  logic [CW:0]   credit_used;
  logic          grant, resp, resp_keep, pop;
  logic          buf_empty, tag_empty;
  word_t         tag_pc;
  fetch_entry_t  buf_wdata, buf_rdata;
  logic          unused_bits;

  assign pop = id_valid && id_ready && !redirect_valid;

  // An entry leaving the buffer this cycle frees its slot for a same-cycle request,
  // which keeps single-cycle memory at one instruction per clock with DEPTH=2.
  assign credit_used = {1'b0, outst_q} + {1'b0, buf_count} - (CW+1)'(pop);
  assign imem_req    = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = pc_q;
  assign grant       = imem_req && imem_gnt;

  assign resp      = imem_rvalid && (outst_q != '0);
  assign resp_keep = resp && (drop_q == '0) && !redirect_valid && !tag_empty;
  assign buf_wdata = '{pc: tag_pc, instr: imem_rdata};

  assign id_valid = !buf_empty;
  assign id_pc    = id_valid ? buf_rdata.pc    : '0;
  assign id_instr = id_valid ? buf_rdata.instr : '0;

  assign unused_bits = ^{tag_count, redirect_pc[1:0]};

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    else if (grant)     pc_d = pc_q + PC_INC;
  end

  // Dropped grants stay outstanding until their response returns, so they
  // keep holding a credit; only their data is thrown away.
  always_comb begin
    outst_d = outst_q + CW'(grant) - CW'(resp);
    drop_d  = drop_q;
    if (redirect_valid)          drop_d = outst_q - CW'(resp);
    else if (resp && drop_q != '0) drop_d = drop_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (grant),
    .wdata_i (pc_q),
    .pop_i   (resp_keep),
    .rdata_o (tag_pc),
    .empty_o (tag_empty),
    .count_o (tag_count)
  );

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (resp_keep),
    .wdata_i (buf_wdata),
    .pop_i   (pop),
    .rdata_o (buf_rdata),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: memory model plus a sequential-PC stream model,
// checked by a negedge monitor against a queue of expected decode PCs.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk, rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_instr;

  if_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_ready       (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          accepted = 0;
  int unsigned cyc = 0;
  int unsigned gnt_pct, rdy_pct, redir_pct, min_lat, max_lat;
  bit          force_redir = 1'b0;
  logic [31:0] force_pc;

  logic [31:0] exp_q [$];
  logic [31:0] gen_pc, req_pc;
  logic [31:0] resp_addr [$];
  int unsigned resp_due [$];
  int unsigned last_due;

  bit          hold_pending = 1'b0;
  logic [31:0] hold_pc, hold_instr, mon_e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    resp_addr.delete();
    resp_due.delete();
    gen_pc   = RST_PC;
    req_pc   = RST_PC;
    last_due = cyc;
  endtask

  task automatic model_redirect(input logic [31:0] tgt);
    exp_q.delete();
    gen_pc = {tgt[31:2], 2'b00};
    req_pc = {tgt[31:2], 2'b00};
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RST_PC);
  endtask

  // Memory and stimulus driver: one iteration per clock.
  task automatic run_cycles(input int n);
    int unsigned due;
    logic [31:0] tgt;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(resp_addr[0]);
        void'(resp_due.pop_front());
        void'(resp_addr.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
      imem_gnt = ($urandom_range(99) < gnt_pct);
      id_ready = ($urandom_range(99) < rdy_pct);
      if (force_redir || ($urandom_range(99) < redir_pct)) begin
        if (force_redir) tgt = force_pc;
        else if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFE0 | $urandom_range(31);
        else tgt = $urandom;
        force_redir    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        model_redirect(tgt);
      end else begin
        redirect_valid = 1'b0;
      end
      while (exp_q.size() < 8) begin
        exp_q.push_back(gen_pc);
        gen_pc = gen_pc + 32'd4;
      end
      @(negedge clk);
      if (redirect_valid) check("req_in_redirect", 32'(imem_req), 32'd0);
      if (imem_req && imem_gnt) begin
        check("imem_addr", imem_addr, req_pc);
        req_pc = req_pc + 32'd4;
        due = cyc + $urandom_range(max_lat, min_lat);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        resp_addr.push_back(imem_addr);
        resp_due.push_back(due);
      end
    end
  endtask

  // Monitor: every accepted decode transfer must be the next expected PC.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 32'(id_valid), 32'd1);
        check("hold_pc", id_pc, hold_pc);
        check("hold_instr", id_instr, hold_instr);
      end
      hold_pending = 1'b0;
      if (id_valid && !redirect_valid) begin
        if (id_ready) begin
          accepted++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL id_extra: got pc %h, no instruction expected", id_pc);
          end else begin
            mon_e = exp_q.pop_front();
            check("id_pc", id_pc, mon_e);
            check("id_instr", id_instr, mem_word(mon_e));
          end
        end else begin
          hold_pending = 1'b1;
          hold_pc      = id_pc;
          hold_instr   = id_instr;
        end
      end
    end
  end

  initial begin
    int a0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_instr", id_instr, 32'd0);
    release_reset();

    // Streaming: single-cycle memory, decode always ready.
    gnt_pct = 100; rdy_pct = 100; redir_pct = 0; min_lat = 1; max_lat = 1;
    run_cycles(10);
    a0 = accepted;
    run_cycles(30);
    check("throughput", 32'(accepted - a0), 32'd30);

    // Decode stall fills the buffer and stops requests.
    rdy_pct = 0;
    run_cycles(6);
    check("req_when_full", 32'(imem_req), 32'd0);
    rdy_pct = 100;
    run_cycles(10);

    // Redirect in a cycle with a response and a pop in flight.
    force_redir = 1'b1; force_pc = 32'h0000_0200;
    run_cycles(1);
    run_cycles(1);
    check("flush_id_valid", 32'(id_valid), 32'd0);
    run_cycles(10);

    // Redirect with two slow grants outstanding; unaligned target.
    min_lat = 6; max_lat = 6;
    force_redir = 1'b1; force_pc = 32'h0000_0040;
    run_cycles(20);
    force_redir = 1'b1; force_pc = 32'h0000_0103;
    run_cycles(25);

    // Address wrap at the top of the space.
    min_lat = 1; max_lat = 1;
    force_redir = 1'b1; force_pc = 32'hFFFF_FFF9;
    run_cycles(12);

    // Random traffic.
    gnt_pct = 70; rdy_pct = 60; redir_pct = 4; min_lat = 1; max_lat = 4;
    run_cycles(1500);
    gnt_pct = 90; rdy_pct = 80; redir_pct = 2; min_lat = 1; max_lat = 8;
    run_cycles(1000);

    // Reset while the buffer is full.
    gnt_pct = 100; rdy_pct = 0; redir_pct = 0; min_lat = 1; max_lat = 1;
    run_cycles(8);
    @(posedge clk); #3;
    rst = 1'b1; imem_rvalid = 1'b0; redirect_valid = 1'b0;
    reset_model();
    #1;
    check("midrst_id_valid", 32'(id_valid), 32'd0);
    check("midrst_imem_req", 32'(imem_req), 32'd0);
    check("midrst_id_pc", id_pc, 32'd0);
    repeat (2) @(posedge clk);
    release_reset();
    gnt_pct = 80; rdy_pct = 70; redir_pct = 3; min_lat = 1; max_lat = 3;
    run_cycles(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
